// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, fixed-latency unified memory between the IF and MEM
// pipeline stages, sequencing one access at a time and returning data with a ready pulse.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_r;
  logic        owner_mem_r;
  logic        acc_we_r;
  logic [3:0]  lat_cnt_r;
  logic [3:0]  starve_cnt_r;
  logic        grant_s;
  logic        if_wins_s;

  // Grant decision: MEM holds the older instruction unless IF has waited too long.
  always_comb begin
    grant_s   = if_req | mem_req;
    if_wins_s = if_req & (~mem_req | (starve_cnt_r == STARVE_LIM));
  end

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

  // Access sequencer with registered memory strobes, read data and ready pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_mem_r  <= 1'b0;
      acc_we_r     <= 1'b0;
      lat_cnt_r    <= 4'd0;
      starve_cnt_r <= 4'd0;
      if_rdata     <= 32'h0;
      mem_rdata    <= 32'h0;
      if_ready     <= 1'b0;
      mem_ready    <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= 32'h0;
      ram_wdata    <= 32'h0;
      busy         <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            state_r     <= ISSUE;
            busy        <= 1'b1;
            ram_en      <= 1'b1;
            owner_mem_r <= ~if_wins_s;
            if (if_wins_s) begin
              ram_addr     <= if_addr;
              ram_we       <= 1'b0;
              ram_wdata    <= 32'h0;
              acc_we_r     <= 1'b0;
              starve_cnt_r <= 4'd0;
            end else begin
              ram_addr     <= mem_addr;
              ram_we       <= mem_we;
              ram_wdata    <= mem_wdata;
              acc_we_r     <= mem_we;
              starve_cnt_r <= if_req ? (starve_cnt_r + 4'd1) : 4'd0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          ram_en    <= 1'b0;
          ram_we    <= 1'b0;
          lat_cnt_r <= LAT_INIT;
          state_r   <= WAIT;
        end
        WAIT: begin
          lat_cnt_r <= lat_cnt_r - 4'd1;
          // ram_rdata is valid in the cycle the counter reads 1.
          if (lat_cnt_r == 4'd1) begin
            state_r <= DONE;
            if (owner_mem_r) begin
              mem_ready <= 1'b1;
              if (!acc_we_r) begin
                mem_rdata <= ram_rdata;
              end
            end else begin
              if_ready <= 1'b1;
              if (!acc_we_r) begin
                if_rdata <= ram_rdata;
              end
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          ram_en  <= 1'b0;
          ram_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
